// File: rtl/exec_pkg.sv
// exec_pkg: shared encodings for the RV32I execute stage.
//   alu_op_e   : 6-bit ALU_Control operation codes (ALU, branch, jump, multiply)
//   OPA_* / OPB_* : operand A / operand B select values
// The multiply codes are always defined here; whether they do anything is
// decided by EXEC_MUL_EN inside the alu.
package exec_pkg;

  typedef enum logic [5:0] {
    OP_ADD    = 6'h00,
    OP_SUB    = 6'h01,
    OP_SLL    = 6'h02,
    OP_SLT    = 6'h03,
    OP_SLTU   = 6'h04,
    OP_XOR    = 6'h05,
    OP_SRL    = 6'h06,
    OP_SRA    = 6'h07,
    OP_OR     = 6'h08,
    OP_AND    = 6'h09,
    OP_BEQ    = 6'h10,
    OP_BNE    = 6'h11,
    OP_BLT    = 6'h14,
    OP_BGE    = 6'h15,
    OP_BLTU   = 6'h16,
    OP_BGEU   = 6'h17,
    OP_JAL    = 6'h20,
    OP_JALR   = 6'h21,
    OP_MUL    = 6'h28,
    OP_MULH   = 6'h29,
    OP_MULHSU = 6'h2A,
    OP_MULHU  = 6'h2B
  } alu_op_e;

  localparam logic [1:0] OPA_RS1  = 2'd0;
  localparam logic [1:0] OPA_PC   = 2'd1;
  localparam logic [1:0] OPA_ZERO = 2'd2;
  localparam logic [1:0] OPA_RS1B = 2'd3;

  localparam logic OPB_RS2 = 1'b0;
  localparam logic OPB_IMM = 1'b1;

endpackage

// File: rtl/execution_alu.sv
// alu: purely combinational 32-bit ALU for the execute stage.
//   i_a, i_b : operands (already muxed by the caller)
//   i_op     : ALU_Control code
//   o_result : 32-bit result; 0 for any code this unit does not implement
//              (branches and jumps are finished by the caller)
// Optional feature macro: EXEC_MUL_EN enables MUL/MULH/MULHSU/MULHU.
module alu
  import exec_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [5:0]  i_op,
  output logic [31:0] o_result
);

`ifdef EXEC_MUL_EN
  // One 64x64 multiplier serves all four variants: each operand is sign- or
  // zero-extended to 64 bits, so the low 64 bits of the product are exact for
  // signed, unsigned and mixed operands alike.
  logic        w_a_sgn;
  logic        w_b_sgn;
  logic [63:0] w_a64;
  logic [63:0] w_b64;
  logic [63:0] w_prod;

  assign w_a_sgn = (i_op == OP_MULH) || (i_op == OP_MULHSU);
  assign w_b_sgn = (i_op == OP_MULH);
  assign w_a64   = {{32{w_a_sgn & i_a[31]}}, i_a};
  assign w_b64   = {{32{w_b_sgn & i_b[31]}}, i_b};
  assign w_prod  = w_a64 * w_b64;
`endif

  always_comb begin
    o_result = 32'd0;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_SLL:  o_result = i_a << i_b[4:0];
      OP_SLT:  o_result = {31'd0, $signed(i_a) < $signed(i_b)};
      OP_SLTU: o_result = {31'd0, i_a < i_b};
      OP_XOR:  o_result = i_a ^ i_b;
      OP_SRL:  o_result = i_a >> i_b[4:0];
      OP_SRA:  o_result = $unsigned($signed(i_a) >>> i_b[4:0]);
      OP_OR:   o_result = i_a | i_b;
      OP_AND:  o_result = i_a & i_b;
`ifdef EXEC_MUL_EN
      OP_MUL:  o_result = w_prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: o_result = w_prod[63:32];
`endif
      default: o_result = 32'd0;
    endcase
  end

endmodule

// File: rtl/execution.sv
// execution: RV32I execute stage.
//   clock, reset (async, active-high)
//   ALU_Control[5:0], op_A_sel[1:0], op_B_sel : operation and operand selects
//   Rdata1, Rdata2, imm32, PC                 : operand sources
//   ALU_result, jump_flag, jump_target_PC     : registered, one-cycle latency
// Optional feature macro: EXEC_MUL_EN (RV32M multiply codes, inside alu).
module execution
  import exec_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  ALU_Control,
  input  logic [1:0]  op_A_sel,
  input  logic        op_B_sel,
  input  logic [31:0] Rdata1,
  input  logic [31:0] Rdata2,
  input  logic [31:0] imm32,
  input  logic [31:0] PC,
  output logic [31:0] ALU_result,
  output logic        jump_flag,
  output logic [31:0] jump_target_PC
);

  logic [31:0] w_op_a;
  logic [31:0] w_op_b;
  logic [31:0] w_alu;
  logic [31:0] w_pc_imm;
  logic [31:0] w_pc_4;
  logic [31:0] w_jalr_tgt;
  logic        w_eq;
  logic        w_lt;
  logic        w_ltu;
  logic [31:0] w_result;
  logic        w_jump;
  logic [31:0] w_target;

  logic [31:0] r_result;
  logic        r_jump;
  logic [31:0] r_target;

  always_comb begin
    case (op_A_sel)
      OPA_PC:   w_op_a = PC;
      OPA_ZERO: w_op_a = 32'd0;
      default:  w_op_a = Rdata1;
    endcase
  end

  assign w_op_b = (op_B_sel == OPB_IMM) ? imm32 : Rdata2;

  alu u_alu (
    .i_a      (w_op_a),
    .i_b      (w_op_b),
    .i_op     (ALU_Control),
    .o_result (w_alu)
  );

  // Branches compare the raw register values, independent of operand selects.
  assign w_eq  = (Rdata1 == Rdata2);
  assign w_lt  = ($signed(Rdata1) < $signed(Rdata2));
  assign w_ltu = (Rdata1 < Rdata2);

  assign w_pc_imm   = PC + imm32;
  assign w_pc_4     = PC + 32'd4;
  assign w_jalr_tgt = (Rdata1 + imm32) & 32'hFFFF_FFFE;

  // The alu already yields 0 for branch/jump codes; this only adds the
  // control-flow outcome and the link value.
  always_comb begin
    w_result = w_alu;
    w_jump   = 1'b0;
    w_target = w_pc_imm;
    case (ALU_Control)
      OP_BEQ:  begin w_result = 32'd0; w_jump = w_eq;   end
      OP_BNE:  begin w_result = 32'd0; w_jump = !w_eq;  end
      OP_BLT:  begin w_result = 32'd0; w_jump = w_lt;   end
      OP_BGE:  begin w_result = 32'd0; w_jump = !w_lt;  end
      OP_BLTU: begin w_result = 32'd0; w_jump = w_ltu;  end
      OP_BGEU: begin w_result = 32'd0; w_jump = !w_ltu; end
      OP_JAL:  begin w_result = w_pc_4; w_jump = 1'b1; end
      OP_JALR: begin w_result = w_pc_4; w_jump = 1'b1; w_target = w_jalr_tgt; end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_result <= 32'd0;
      r_jump   <= 1'b0;
      r_target <= 32'd0;
    end else begin
      r_result <= w_result;
      r_jump   <= w_jump;
      r_target <= w_target;
    end
  end

  assign ALU_result     = r_result;
  assign jump_flag      = r_jump;
  assign jump_target_PC = r_target;

endmodule

// File: tb/tb_execution.sv
module tb_execution;

  logic        clock;
  logic        reset;
  logic [5:0]  ALU_Control;
  logic [1:0]  op_A_sel;
  logic        op_B_sel;
  logic [31:0] Rdata1, Rdata2, imm32, PC;
  logic [31:0] ALU_result;
  logic        jump_flag;
  logic [31:0] jump_target_PC;

  execution dut (
    .clock          (clock),
    .reset          (reset),
    .ALU_Control    (ALU_Control),
    .op_A_sel       (op_A_sel),
    .op_B_sel       (op_B_sel),
    .Rdata1         (Rdata1),
    .Rdata2         (Rdata2),
    .imm32          (imm32),
    .PC             (PC),
    .ALU_result     (ALU_result),
    .jump_flag      (jump_flag),
    .jump_target_PC (jump_target_PC)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  ctl;
    logic [1:0]  asel;
    logic        bsel;
    logic [31:0] r1, r2, imm, pc;
    logic [31:0] res;
    logic        jf;
    logic [31:0] tgt;
  } vec_t;

  vec_t vt[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input logic [5:0] ctl, input logic [1:0] asel, input logic bsel,
                     input logic [31:0] r1, r2, imm, pc, res, input logic jf,
                     input logic [31:0] tgt);
    vec_t v;
    v.ctl = ctl; v.asel = asel; v.bsel = bsel; v.r1 = r1; v.r2 = r2;
    v.imm = imm; v.pc = pc; v.res = res; v.jf = jf; v.tgt = tgt;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] ctl, input logic [1:0] asel, input logic bsel,
                       input logic [31:0] r1, r2, imm, pc);
    ALU_Control = ctl; op_A_sel = asel; op_B_sel = bsel;
    Rdata1 = r1; Rdata2 = r2; imm32 = imm; PC = pc;
  endtask

  initial begin
    // ctl    asel bsel r1            r2            imm           pc            res           jf    tgt
    add(6'h00, 2'd0, 1'b1, 32'hFFFF_FFFF, 32'h0,        32'h1,        32'h0,        32'h0,        1'b0, 32'h1);
    add(6'h07, 2'd0, 1'b0, 32'h8000_0000, 32'h24,       32'h0,        32'h0,        32'hF800_0000, 1'b0, 32'h0);
    add(6'h03, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h1,        32'h0,        32'h0,        32'h1,        1'b0, 32'h0);
    add(6'h04, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h1,        32'h0,        32'h0,        32'h0,        1'b0, 32'h0);
    add(6'h11, 2'd1, 1'b1, 32'h5,         32'h5,        32'hFFFF_FFF8, 32'h100,     32'h0,        1'b0, 32'hF8);
    add(6'h11, 2'd1, 1'b1, 32'h5,         32'h6,        32'hFFFF_FFF8, 32'h100,     32'h0,        1'b1, 32'hF8);
    add(6'h21, 2'd0, 1'b1, 32'h1001,      32'h0,        32'h2,        32'h40,       32'h44,       1'b1, 32'h1002);
    add(6'h00, 2'd1, 1'b1, 32'h123,       32'h0,        32'h2_0000,   32'h1000,     32'h2_1000,   1'b0, 32'h2_1000);
    add(6'h00, 2'd2, 1'b1, 32'h123,       32'h0,        32'h2_0000,   32'h1000,     32'h2_0000,   1'b0, 32'h2_1000);
    add(6'h00, 2'd3, 1'b0, 32'h10,        32'h20,       32'h0,        32'h0,        32'h30,       1'b0, 32'h0);
    add(6'h01, 2'd0, 1'b0, 32'h0,         32'h1,        32'h0,        32'h0,        32'hFFFF_FFFF, 1'b0, 32'h0);
    add(6'h02, 2'd0, 1'b0, 32'h1,         32'h3F,       32'h0,        32'h0,        32'h8000_0000, 1'b0, 32'h0);
    add(6'h06, 2'd0, 1'b0, 32'h8000_0000, 32'h4,        32'h0,        32'h0,        32'h0800_0000, 1'b0, 32'h0);
    add(6'h05, 2'd0, 1'b0, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h0,       32'h0,        32'h5A5A_A5A5, 1'b0, 32'h0);
    add(6'h08, 2'd0, 1'b0, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0,       32'h0,        32'hF0F0_0F0F, 1'b0, 32'h0);
    add(6'h09, 2'd0, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0,       32'h0,        32'h0F00_0F00, 1'b0, 32'h0);
    add(6'h10, 2'd0, 1'b0, 32'h7,         32'h7,        32'h8,        32'hFFFF_FFFC, 32'h0,       1'b1, 32'h4);
    add(6'h14, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h1,        32'h10,       32'h0,        32'h0,        1'b1, 32'h10);
    add(6'h16, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h1,        32'h10,       32'h0,        32'h0,        1'b0, 32'h10);
    add(6'h15, 2'd0, 1'b0, 32'h1,         32'hFFFF_FFFF, 32'h10,      32'h0,        32'h0,        1'b1, 32'h10);
    add(6'h17, 2'd0, 1'b0, 32'h1,         32'hFFFF_FFFF, 32'h10,      32'h0,        32'h0,        1'b0, 32'h10);
    add(6'h20, 2'd0, 1'b1, 32'h0,         32'h0,        32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,      1'b1, 32'hFFFF_FFF8);
    add(6'h3F, 2'd0, 1'b0, 32'h9,         32'h9,        32'h20,       32'h10,       32'h0,        1'b0, 32'h30);
`ifdef EXEC_MUL_EN
    add(6'h2B, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,       32'h0,        32'hFFFF_FFFE, 1'b0, 32'h0);
    add(6'h29, 2'd0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0,       32'h0,        32'h4000_0000, 1'b0, 32'h0);
    add(6'h2A, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h2,        32'h0,        32'h0,        32'hFFFF_FFFF, 1'b0, 32'h0);
    add(6'h28, 2'd0, 1'b0, 32'h3,         32'hFFFF_FFFE, 32'h0,       32'h0,        32'hFFFF_FFFA, 1'b0, 32'h0);
`else
    add(6'h2B, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,       32'h0,        32'h0,        1'b0, 32'h0);
    add(6'h29, 2'd0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0,       32'h0,        32'h0,        1'b0, 32'h0);
    add(6'h2A, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h2,        32'h0,        32'h0,        32'h0,        1'b0, 32'h0);
    add(6'h28, 2'd0, 1'b0, 32'h3,         32'hFFFF_FFFE, 32'h0,       32'h0,        32'h0,        1'b0, 32'h0);
`endif

    // Reset state, inputs set to something that would give non-zero outputs.
    reset = 1'b1;
    drive(6'h20, 2'd0, 1'b1, 32'h0, 32'h0, 32'h8, 32'h100);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_res", 0, ALU_result, 32'h0);
    chk("rst_jf",  0, {31'd0, jump_flag}, 32'h0);
    chk("rst_tgt", 0, jump_target_PC, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Back-to-back vectors, one per cycle.
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].ctl, vt[i].asel, vt[i].bsel, vt[i].r1, vt[i].r2, vt[i].imm, vt[i].pc);
      @(posedge clock);
      #1;
      chk("res", i, ALU_result, vt[i].res);
      chk("jf",  i, {31'd0, jump_flag}, {31'd0, vt[i].jf});
      chk("tgt", i, jump_target_PC, vt[i].tgt);
      @(negedge clock);
    end

    // Mid-stream reset after a JAL: outputs clear without waiting for an edge.
    drive(6'h20, 2'd1, 1'b1, 32'h0, 32'h0, 32'h40, 32'h200);
    @(posedge clock);
    #1;
    chk("jal_res", 100, ALU_result, 32'h204);
    chk("jal_jf",  100, {31'd0, jump_flag}, 32'h1);
    chk("jal_tgt", 100, jump_target_PC, 32'h240);
    #2 reset = 1'b1;
    #1;
    chk("arst_res", 101, ALU_result, 32'h0);
    chk("arst_jf",  101, {31'd0, jump_flag}, 32'h0);
    chk("arst_tgt", 101, jump_target_PC, 32'h0);
    @(posedge clock);
    #1;
    chk("hold_jf", 102, {31'd0, jump_flag}, 32'h0);
    chk("hold_res", 102, ALU_result, 32'h0);
    // First edge after release captures the inputs present then.
    @(negedge clock);
    reset = 1'b0;
    drive(6'h00, 2'd0, 1'b0, 32'h7, 32'h8, 32'h4, 32'h10);
    @(posedge clock);
    #1;
    chk("post_res", 103, ALU_result, 32'hF);
    chk("post_jf",  103, {31'd0, jump_flag}, 32'h0);
    chk("post_tgt", 103, jump_target_PC, 32'h14);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
